// File: rtl/lcd_pkg.sv
// Shared types, HD44780 command constants and helpers for the LCD controller.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    SETUP,
    PULSE,
    HOLD,
    WAIT,
    IDLE
  } lcd_state_e;

  localparam logic [7:0] LCD_INIT_FUNCSET = 8'h38;
  localparam logic [7:0] LCD_INIT_DISPON  = 8'h0C;
  localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_INIT_ENTRY   = 8'h06;
  localparam logic [7:0] LCD_CMD_HOME     = 8'h02;

  // Clear and both home encodings need the long execution wait.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == LCD_CMD_CLEAR || data == LCD_CMD_HOME || data == 8'h03);
  endfunction

  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    case (idx)
      2'd0:    return LCD_INIT_FUNCSET;
      2'd1:    return LCD_INIT_DISPON;
      2'd2:    return LCD_CMD_CLEAR;
      default: return LCD_INIT_ENTRY;
    endcase
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter with zero flag; holds at zero until reloaded.
module lcd_delay_cnt #(
  parameter int unsigned W       = 4,
  parameter int unsigned RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= W'(RST_VAL);
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write sequencer: power-up wait, 4-command init, then LSU-driven writes.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned T_POWERUP = 750000,
  parameter int unsigned T_SETUP   = 4,
  parameter int unsigned T_PULSE   = 12,
  parameter int unsigned T_HOLD    = 2,
  parameter int unsigned T_CMD     = 2500,
  parameter int unsigned T_CLR     = 82000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  input  logic       cmd_rs_i,
  input  logic [7:0] cmd_data_i,
  output logic       cmd_ready_o,
  input  logic       lcd_on_i,
  output logic       init_done_o,
  output logic       busy_o,
  output logic       lcd_on_o,
  output logic       lcd_en_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic [7:0] lcd_data_o
);

  localparam int unsigned T_MAX = max2(max2(max2(T_POWERUP, T_SETUP), max2(T_PULSE, T_HOLD)),
                                       max2(T_CMD, T_CLR));
  localparam int unsigned CW = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [CW-1:0] L_SETUP = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] L_PULSE = CW'(T_PULSE - 1);
  localparam logic [CW-1:0] L_HOLD  = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] L_CMD   = CW'(T_CMD - 1);
  localparam logic [CW-1:0] L_CLR   = CW'(T_CLR - 1);

  lcd_state_e    state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic          done_q, done_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          en_q, ready_q, on_q;
  logic          load;
  logic [CW-1:0] load_val;
  logic          cnt_zero;

  lcd_delay_cnt #(
    .W       (CW),
    .RST_VAL (T_POWERUP - 1)
  ) u_cnt (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (load),
    .load_val (load_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    done_d   = done_q;
    rs_d     = rs_q;
    data_d   = data_q;
    load     = 1'b0;
    load_val = '0;
    case (state_q)
      PWR_WAIT: if (cnt_zero) begin
        state_d  = SETUP;
        rs_d     = 1'b0;
        data_d   = init_rom(2'd0);
        load     = 1'b1;
        load_val = L_SETUP;
      end
      SETUP: if (cnt_zero) begin
        state_d  = PULSE;
        load     = 1'b1;
        load_val = L_PULSE;
      end
      PULSE: if (cnt_zero) begin
        state_d  = HOLD;
        load     = 1'b1;
        load_val = L_HOLD;
      end
      HOLD: if (cnt_zero) begin
        state_d  = WAIT;
        load     = 1'b1;
        load_val = is_slow_cmd(rs_q, data_q) ? L_CLR : L_CMD;
      end
      WAIT: if (cnt_zero) begin
        if (!done_q && idx_q != 2'd3) begin
          idx_d    = idx_q + 2'd1;
          state_d  = SETUP;
          rs_d     = 1'b0;
          data_d   = init_rom(idx_q + 2'd1);
          load     = 1'b1;
          load_val = L_SETUP;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      IDLE: if (cmd_valid_i) begin
        state_d  = SETUP;
        rs_d     = cmd_rs_i;
        data_d   = cmd_data_i;
        load     = 1'b1;
        load_val = L_SETUP;
      end
      default: state_d = PWR_WAIT;
    endcase
  end

  // Pin registers decode the next state so EN/ready change on the same edge as the FSM.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= PWR_WAIT;
      idx_q   <= '0;
      done_q  <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= '0;
      en_q    <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      en_q    <= (state_d == PULSE);
      ready_q <= (state_d == IDLE);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      on_q <= 1'b0;
    else
      on_q <= lcd_on_i;
  end

  assign cmd_ready_o = ready_q;
  assign busy_o      = ~ready_q;
  assign init_done_o = done_q;
  assign lcd_on_o    = on_q;
  assign lcd_en_o    = en_q;
  assign lcd_rs_o    = rs_q;
  assign lcd_rw_o    = 1'b0;
  assign lcd_data_o  = data_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: expected EN pulses and ready-return times are queued at stimulus.
module tb_lcd_ctrl;

  localparam int TP  = 4;
  localparam int TS  = 2;
  localparam int TPU = 3;
  localparam int TH  = 1;
  localparam int TC  = 5;
  localparam int TCL = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_rs = 1'b0;
  logic [7:0] cmd_data = '0;
  logic       lcd_on_in = 1'b0;
  logic       cmd_ready, init_done, busy, lcd_on, lcd_en, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;

  lcd_ctrl #(
    .T_POWERUP (TP),
    .T_SETUP   (TS),
    .T_PULSE   (TPU),
    .T_HOLD    (TH),
    .T_CMD     (TC),
    .T_CLR     (TCL)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_rs_i    (cmd_rs),
    .cmd_data_i  (cmd_data),
    .cmd_ready_o (cmd_ready),
    .lcd_on_i    (lcd_on_in),
    .init_done_o (init_done),
    .busy_o      (busy),
    .lcd_on_o    (lcd_on),
    .lcd_en_o    (lcd_en),
    .lcd_rs_o    (lcd_rs),
    .lcd_rw_o    (lcd_rw),
    .lcd_data_o  (lcd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         rise;
  } pulse_t;

  pulse_t pq[$];
  int     rq[$];
  int     checks = 0;
  int     failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cyc %0d", name, act, exp, cyc);
    end
  endtask

  // Execution wait from the command rules: clear/home (RS=0, 0x01..0x03) are slow.
  function automatic int twait(input logic rs, input logic [7:0] d);
    return (!rs && d >= 8'h01 && d <= 8'h03) ? TCL : TC;
  endfunction

  // k is the edge at which the command enters SETUP; times are cycle indices seen at posedge+1.
  task automatic push_cmd(input int k, input logic rs, input logic [7:0] d, input bit want_ready);
    pq.push_back('{rs, d, k + TS});
    if (want_ready) rq.push_back(k + TS + TPU + TH + twait(rs, d));
  endtask

  task automatic seed_init(input int e0);
    logic [7:0] rom [4];
    int k;
    rom[0] = 8'h38; rom[1] = 8'h0C; rom[2] = 8'h01; rom[3] = 8'h06;
    k = e0 + TP;
    for (int i = 0; i < 4; i++) begin
      push_cmd(k, 1'b0, rom[i], i == 3);
      k += TS + TPU + TH + twait(1'b0, rom[i]);
    end
  endtask

  // Monitor: compares observed pulses and ready edges against the queued expectations.
  initial begin
    pulse_t cur;
    bit has_cur = 0;
    bit en_prev = 0, rdy_prev = 0;
    int rise_at = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        pq.delete();
        rq.delete();
        en_prev = 0; rdy_prev = 0; has_cur = 0;
        chk("rst_en", lcd_en, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_busy", busy, 1);
        chk("rst_init_done", init_done, 0);
        chk("rst_rs_data", {lcd_rs, lcd_data}, 0);
        chk("rst_lcd_on", lcd_on, 0);
      end else begin
        chk("busy_inv", busy, !cmd_ready);
        chk("rw_zero", lcd_rw, 0);
        chk("lcd_on_follow", lcd_on, lcd_on_in);
        if (lcd_en && !en_prev) begin
          if (pq.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_pulse actual=data %0h required=no pulse at cyc %0d", lcd_data, cyc);
          end else begin
            cur = pq.pop_front();
            has_cur = 1;
            rise_at = cyc;
            chk("en_rise_time", cyc, cur.rise);
            chk("pulse_rs", lcd_rs, cur.rs);
            chk("pulse_data", lcd_data, cur.data);
          end
        end
        if (lcd_en && en_prev && has_cur)
          chk("data_stable", {lcd_rs, lcd_data}, {cur.rs, cur.data});
        if (!lcd_en && en_prev)
          chk("pulse_width", cyc - rise_at, TPU);
        if (cmd_ready && !rdy_prev) begin
          if (rq.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_ready actual=1 required=0 at cyc %0d", cyc);
          end else begin
            chk("ready_time", cyc, rq.pop_front());
          end
          chk("init_done_at_ready", init_done, 1);
          if (has_cur) chk("idle_keeps_data", {lcd_rs, lcd_data}, {cur.rs, cur.data});
        end
        en_prev = lcd_en;
        rdy_prev = cmd_ready;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) lcd_on_in = ~lcd_on_in;
    end
  end

  task automatic wait_ready(output int t);
    t = -1;
    for (int i = 0; i < 400; i++) begin
      if (cmd_ready) begin
        t = cyc;
        return;
      end
      @(negedge clk);
    end
    checks++; failures++;
    $display("FAIL wait_ready_timeout actual=0 required=1 at cyc %0d", cyc);
  endtask

  task automatic wait_en();
    for (int i = 0; i < 100; i++) begin
      if (lcd_en) return;
      @(negedge clk);
    end
    checks++; failures++;
    $display("FAIL wait_en_timeout actual=0 required=1 at cyc %0d", cyc);
  endtask

  // Called at a negedge; returns the handshake edge index.
  task automatic write(input logic rs, input logic [7:0] d, input bit hold, output int k);
    cmd_valid = 1'b1;
    cmd_rs = rs;
    cmd_data = d;
    k = -1;
    for (int i = 0; i < 400; i++) begin
      if (cmd_ready) begin
        k = cyc + 1;
        push_cmd(k, rs, d, 1'b1);
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    checks++; failures++;
    $display("FAIL write_timeout actual=not accepted required=accepted at cyc %0d", cyc);
  endtask

  initial begin
    int e0, t, k, k1, k2, k3;
    logic rs;
    logic [7:0] d;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    e0 = cyc;
    seed_init(e0);
    wait_ready(t);
    chk("init_latency", t - e0, 53);

    write(1'b1, 8'h41, 1'b0, k);
    write(1'b0, 8'h01, 1'b1, k1);
    write(1'b0, 8'h80, 1'b1, k2);
    chk("b2b_gap_clear", k2 - k1, 17);
    write(1'b0, 8'h80, 1'b0, k3);
    chk("b2b_gap_cmd", k3 - k2, 12);

    write(1'b1, 8'h5A, 1'b0, k);
    wait_en();
    cmd_valid = 1'b1;
    cmd_rs = 1'b0;
    cmd_data = 8'($urandom);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_ready(t);

    write(1'b1, 8'h33, 1'b0, k);
    wait_en();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    e0 = cyc;
    seed_init(e0);
    wait_ready(t);
    chk("reinit_latency", t - e0, 53);

    repeat (25) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        rs = 1'b0;
        d = 8'($urandom_range(1, 3));
      end else begin
        rs = 1'($urandom_range(0, 1));
        d = 8'($urandom);
      end
      write(rs, d, 1'($urandom_range(0, 1)), k);
    end
    cmd_valid = 1'b0;
    wait_ready(t);
    repeat (3) @(negedge clk);
    chk("pulses_outstanding", pq.size(), 0);
    chk("ready_outstanding", rq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
